// File: rtl/nq_pkg.sv
// Shared widths, FSM state encoding and constants for the N-Queens sweep controller.
package nq_pkg;

    localparam int unsigned N_W   = 5;
    localparam int unsigned SUM_W = 24;

    localparam logic [SUM_W-1:0] SUM_ALL_ONES = '1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_STORE = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/nq_result_ram.sv
// Result table: 2^N_W x SUM_W synchronous-read RAM with per-entry valid bits and bulk clear.
module nq_result_ram
    import nq_pkg::*;
#(
    parameter int unsigned LO = 1,
    parameter int unsigned HI = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             we,
    input  logic [N_W-1:0]   wr_addr,
    input  logic [SUM_W-1:0] wr_data,
    input  logic [N_W-1:0]   rd_addr,
    output logic [SUM_W-1:0] rd_data,
    output logic             rd_valid
);

    localparam int unsigned DEPTH = 1 << N_W;

    logic [SUM_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic             in_range_c;

    assign in_range_c = (rd_addr >= N_W'(LO)) && (rd_addr <= N_W'(HI));

    // Data array carries no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            vld <= '0;
        end else if (we) begin
            vld[wr_addr] <= 1'b1;
        end
    end

    // Read samples pre-write contents, so a same-address write returns old data/valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_data  <= in_range_c ? mem[rd_addr] : '0;
            rd_valid <= in_range_c && vld[rd_addr];
        end
    end

endmodule

// File: rtl/nq_sweep_controller.sv
// Sweeps accelerator board size N_MIN..N_MAX, pulsing its reset and logging each solution count.
// Optional RUN watchdog with timeout_err output enabled by NQ_SWEEP_TIMEOUT_EN.
module nq_sweep_controller
    import nq_pkg::*;
#(
    parameter int unsigned N_MIN      = 1,
    parameter int unsigned N_MAX      = 16,
    parameter int unsigned RST_CYCLES = 4
`ifdef NQ_SWEEP_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 32'd16777216
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             sweep_done,
    output logic [N_W-1:0]   acc_n,
    output logic             acc_reset,
    input  logic [SUM_W-1:0] acc_sum,
    input  logic             acc_done,
    input  logic [N_W-1:0]   rd_addr,
    output logic [SUM_W-1:0] rd_data,
    output logic             rd_valid
`ifdef NQ_SWEEP_TIMEOUT_EN
    ,
    output logic             timeout_err
`endif
);

    localparam int unsigned CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             run_armed, run_armed_d;
    logic             busy_d, sweep_done_d, acc_reset_d;
    logic [N_W-1:0]   acc_n_d;
    logic             clr_c, we_c;
    logic [SUM_W-1:0] wr_data_c;
`ifdef NQ_SWEEP_TIMEOUT_EN
    logic [31:0]      wdog, wdog_d;
    logic             timed_out, timed_out_d;
    logic             timeout_err_d;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        run_armed_d  = run_armed;
        busy_d       = busy;
        sweep_done_d = sweep_done;
        acc_reset_d  = acc_reset;
        acc_n_d      = acc_n;
        clr_c        = 1'b0;
        we_c         = 1'b0;
        wr_data_c    = acc_sum;
`ifdef NQ_SWEEP_TIMEOUT_EN
        wdog_d        = wdog;
        timed_out_d   = timed_out;
        timeout_err_d = timeout_err;
`endif
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    acc_n_d      = N_W'(N_MIN);
                    acc_reset_d  = 1'b1;
                    clr_c        = 1'b1;
                    sweep_done_d = 1'b0;
                    busy_d       = 1'b1;
                    cnt_d        = CNT_W'(RST_CYCLES - 1);
`ifdef NQ_SWEEP_TIMEOUT_EN
                    timeout_err_d = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                acc_reset_d = 1'b1;
                if (cnt == '0) begin
                    state_d     = ST_RUN;
                    acc_reset_d = 1'b0;
                    run_armed_d = 1'b0;
`ifdef NQ_SWEEP_TIMEOUT_EN
                    wdog_d = '0;
`endif
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            ST_RUN: begin
                // First RUN cycle may still see done left over from the previous job.
                run_armed_d = 1'b1;
                if (run_armed && acc_done) begin
                    state_d     = ST_STORE;
                    acc_reset_d = 1'b1;
`ifdef NQ_SWEEP_TIMEOUT_EN
                    timed_out_d = 1'b0;
                end else if (wdog == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = ST_STORE;
                    acc_reset_d   = 1'b1;
                    timed_out_d   = 1'b1;
                    timeout_err_d = 1'b1;
                end else begin
                    wdog_d = wdog + 32'd1;
`endif
                end
            end
            ST_STORE: begin
                we_c    = 1'b1;
`ifdef NQ_SWEEP_TIMEOUT_EN
                wr_data_c = timed_out ? SUM_ALL_ONES : acc_sum;
`endif
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (acc_n == N_W'(N_MAX)) begin
                    state_d      = ST_DONE;
                    busy_d       = 1'b0;
                    sweep_done_d = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                    acc_n_d = acc_n + N_W'(1);
                    cnt_d   = CNT_W'(RST_CYCLES - 1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                acc_reset_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            run_armed  <= 1'b0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
            acc_n      <= N_W'(N_MIN);
            acc_reset  <= 1'b1;
`ifdef NQ_SWEEP_TIMEOUT_EN
            wdog        <= '0;
            timed_out   <= 1'b0;
            timeout_err <= 1'b0;
`endif
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            run_armed  <= run_armed_d;
            busy       <= busy_d;
            sweep_done <= sweep_done_d;
            acc_n      <= acc_n_d;
            acc_reset  <= acc_reset_d;
`ifdef NQ_SWEEP_TIMEOUT_EN
            wdog        <= wdog_d;
            timed_out   <= timed_out_d;
            timeout_err <= timeout_err_d;
`endif
        end
    end

    nq_result_ram #(
        .LO (N_MIN),
        .HI (N_MAX)
    ) u_ram (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr_c),
        .we       (we_c),
        .wr_addr  (acc_n),
        .wr_data  (wr_data_c),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

endmodule

// File: tb/tb_nq_sweep_controller.sv
// Scoreboard bench for nq_sweep_controller with a behavioural N-Queens accelerator model.
module tb_nq_sweep_controller;
    import nq_pkg::*;

    localparam int unsigned N_MIN = 1;
    localparam int unsigned N_MAX = 8;
    localparam int unsigned RST   = 4;

    logic             clk = 1'b0;
    logic             reset, start;
    logic             busy, sweep_done, acc_reset, acc_done, rd_valid;
    logic [N_W-1:0]   acc_n, rd_addr;
    logic [SUM_W-1:0] acc_sum, rd_data;
`ifdef NQ_SWEEP_TIMEOUT_EN
    logic             timeout_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nq_sweep_controller #(
        .N_MIN      (N_MIN),
        .N_MAX      (N_MAX),
        .RST_CYCLES (RST)
`ifdef NQ_SWEEP_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (100)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .sweep_done (sweep_done),
        .acc_n      (acc_n),
        .acc_reset  (acc_reset),
        .acc_sum    (acc_sum),
        .acc_done   (acc_done),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid)
`ifdef NQ_SWEEP_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    function automatic int nq_count(input int n);
        case (n)
            1: return 1;  2: return 0;  3: return 0;  4: return 2;
            5: return 10; 6: return 4;  7: return 40; 8: return 92;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Accelerator model: done rises k cycles after reset falls; stale mode holds old done into RUN.
    bit stale_mode = 1'b0;
    int no_done_n  = -1;
    int rc, k_lat;
    initial begin
        acc_done = 1'b0;
        acc_sum  = '0;
        rc       = 0;
        k_lat    = 4;
        forever begin
            @(posedge clk);
            #1;
            if (acc_reset) begin
                rc = 0;
                if (!stale_mode) acc_done = 1'b0;
                k_lat = $urandom_range(3, 12);
            end else begin
                rc++;
                if (rc == 2) begin
                    acc_done = 1'b0;
                    acc_sum  = SUM_W'($urandom);
                end
                if (rc == k_lat && int'(acc_n) != no_done_n) begin
                    acc_done = 1'b1;
                    acc_sum  = SUM_W'(nq_count(int'(acc_n)));
                end
            end
        end
    end

    // Reset pulse length and job order observed at each RUN entry.
    int             len = 0;
    logic [N_W-1:0] len_n = '0;
    logic           prev_rst = 1'b1;
    int             exp_job_n = N_MIN;
    always @(negedge clk) begin
        if (busy && acc_reset) begin
            len   = (len > 0 && acc_n == len_n) ? len + 1 : 1;
            len_n = acc_n;
        end else if (busy && !acc_reset && prev_rst) begin
            chk("rst_len", len, RST);
            chk("job_n", acc_n, exp_job_n);
            exp_job_n++;
            len = 0;
        end else if (!busy) begin
            len = 0;
        end
        prev_rst = acc_reset;
    end

    // Reference table and read scoreboard.
    typedef struct {
        logic [N_W-1:0]   addr;
        logic [SUM_W-1:0] d;
        logic             v;
        bit               chk_d;
    } rd_exp_t;

    rd_exp_t          sbq[$];
    logic [SUM_W-1:0] ref_d [32];
    bit               ref_v [32];
    logic             rd_req = 1'b0;
    logic             rd_req_q = 1'b0;

    always @(posedge clk) rd_req_q <= rd_req;

    always @(negedge clk) begin
        if (rd_req_q) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                rd_exp_t e;
                e = sbq.pop_front();
                chk($sformatf("rd_valid[%0d]", e.addr), rd_valid, e.v);
                if (e.chk_d) chk($sformatf("rd_data[%0d]", e.addr), rd_data, e.d);
            end
        end
    end

    task automatic rd(input int a);
        rd_exp_t e;
        bit in_rng;
        in_rng  = (a >= int'(N_MIN)) && (a <= int'(N_MAX));
        e.addr  = N_W'(a);
        e.v     = in_rng && ref_v[a];
        e.d     = in_rng ? ref_d[a] : '0;
        e.chk_d = !in_rng || e.v;
        sbq.push_back(e);
        rd_addr = N_W'(a);
        rd_req  = 1'b1;
        @(negedge clk);
        rd_req  = 1'b0;
    endtask

    task automatic read_all();
        int order [8];
        for (int i = 0; i < 8; i++) order[i] = i + 1;
        order.shuffle();
        foreach (order[i]) rd(order[i]);
        rd(0);
        rd(9);
        for (int i = 0; i < 4; i++) rd($urandom_range(0, 31));
        @(negedge clk);
    endtask

    task automatic start_sweep();
        for (int i = 0; i < 32; i++) ref_v[i] = 1'b0;
        exp_job_n = N_MIN;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_after_start", sweep_done, 0);
        chk("acc_n_after_start", acc_n, N_MIN);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 5000 && !sweep_done; i++) @(negedge clk);
        chk("sweep_done", sweep_done, 1);
        chk("busy_at_done", busy, 0);
        chk("acc_n_at_done", acc_n, N_MAX);
        chk("acc_reset_at_done", acc_reset, 1);
        for (int n = N_MIN; n <= int'(N_MAX); n++) begin
            ref_v[n] = 1'b1;
            ref_d[n] = (n == no_done_n) ? SUM_W'(24'hFFFFFF) : SUM_W'(nq_count(n));
        end
    endtask

    task automatic wait_run_n(input int n);
        int i;
        for (i = 0; i < 2000 && !(busy && !acc_reset && int'(acc_n) == n); i++) @(negedge clk);
        chk($sformatf("reach_run_n%0d", n), (i < 2000) ? 1 : 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            ref_v[i] = 1'b0;
            ref_d[i] = '0;
        end
        reset   = 1'b1;
        start   = 1'b0;
        rd_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_sweep_done", sweep_done, 0);
        chk("rst_acc_n", acc_n, N_MIN);
        chk("rst_acc_reset", acc_reset, 1);
        chk("rst_rd_valid", rd_valid, 0);
`ifdef NQ_SWEEP_TIMEOUT_EN
        chk("rst_timeout_err", timeout_err, 0);
`endif
        reset = 1'b0;
        @(negedge clk);
        rd(1);
        rd(20);

        // Basic sweep.
        start_sweep();
        wait_done();
        read_all();

        // Stale done plus a start pulse while n=5 is running.
        stale_mode = 1'b1;
        start_sweep();
        rd(4);
        wait_run_n(5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_ignore_start", busy, 1);
        chk("acc_n_ignore_start", acc_n, 5);
        wait_done();
        read_all();
        stale_mode = 1'b0;

        // Reset while n=6 is running.
        start_sweep();
        wait_run_n(6);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_acc_reset", acc_reset, 1);
        chk("midrst_acc_n", acc_n, N_MIN);
        chk("midrst_sweep_done", sweep_done, 0);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) ref_v[i] = 1'b0;
        read_all();

`ifdef NQ_SWEEP_TIMEOUT_EN
        // Accelerator never finishes n=3; watchdog fills the entry and the sweep continues.
        no_done_n = 3;
        start_sweep();
        chk("timeout_err_cleared", timeout_err, 0);
        wait_done();
        chk("timeout_err_set", timeout_err, 1);
        read_all();
        no_done_n = -1;
`endif

        repeat (2) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nq_sweep_controller.md
Name: nq_sweep_controller

Overview:
- Upstream sequencer for the N-Queens accelerator. It sweeps the board size n from N_MIN to N_MAX and, for each n, drives the accelerator's n/reset inputs.
- It waits for the accelerator's done, then captures its 24-bit solution count into a result table. A host reads the table afterwards.
- Lets the whole solution-count series be produced in one run without a bench re-driving n and reset by hand.

Parameters:
- N_W, 5, width of board-size bus (matches accelerator n).
- SUM_W, 24, width of accelerator solution count.
- N_MIN, 1, first board size swept.
- N_MAX, 16, last board size swept (N_MIN <= N_MAX <= 2^N_W-1).
- RST_CYCLES, 4, cycles acc_reset is held high per job (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a sweep when idle.
- busy  out  1  high from the cycle after an accepted start until sweep completes.
- sweep_done  out  1  high in DONE state; cleared by next accepted start or reset.
- acc_n  out  N_W  board size to accelerator.
- acc_reset  out  1  reset to accelerator (active-high).
- acc_sum  in  SUM_W  accelerator solution count.
- acc_done  in  1  accelerator done, level; stays high until acc_reset.
- rd_addr  in  N_W  table read address (board size n).
- rd_data  out  SUM_W  registered table word.
- rd_valid  out  1  registered: addressed entry written this sweep.

Behaviour:
- Reset values:
  - busy=0, sweep_done=0.
  - acc_n=N_MIN, acc_reset=1 (accelerator held in reset while idle).
  - rd_data=0, rd_valid=0.
  - All table valid bits cleared; RAM data not reset.
  - State=IDLE, reset counter=0.
- FSM states IDLE, LOAD, RUN, STORE, NEXT, DONE:
  - IDLE/DONE: on start=1, go to LOAD. Set acc_n=N_MIN, clear all valid bits and sweep_done, set busy=1, load reset counter.
  - LOAD: acc_reset=1, acc_n stable. Stay exactly RST_CYCLES cycles, then go to RUN.
  - RUN: acc_reset=0. acc_done is ignored on the first RUN cycle (stale-done guard). On any later cycle with acc_done=1, go to STORE.
  - STORE: write acc_sum into table[acc_n] and set its valid bit. acc_reset is driven 1 again from this cycle. Then go to NEXT.
  - NEXT: if acc_n==N_MAX, go to DONE (busy=0, sweep_done=1). Otherwise acc_n+1, reload counter, go to LOAD.
  - DONE: acc_reset=1, acc_n holds N_MAX.
- start is ignored in LOAD/RUN/STORE/NEXT.
- acc_done is ignored in every state except RUN.
- Per-job overhead outside RUN is RST_CYCLES+2 cycles.
- Table read:
  - Synchronous, 1-cycle latency; reads are allowed in any state.
  - If rd_addr is outside [N_MIN,N_MAX]: rd_data=0, rd_valid=0.
  - Same-cycle write and read of the same address returns the old data and old valid (read-before-write).
- Reset mid-sweep: next state IDLE, acc_reset=1, valid bits cleared, busy=0; in-flight result discarded.
- acc_sum is captured unmodified; there is no arithmetic on it. The acc_n increment cannot wrap because N_MAX < 2^N_W.

Optional Feature:
- Macro: NQ_SWEEP_TIMEOUT_EN.
- Defined:
  - Adds a 32-bit watchdog cleared on LOAD->RUN and a parameter TIMEOUT_CYCLES (default 2^24).
  - If RUN lasts TIMEOUT_CYCLES cycles without acc_done, go to STORE and write all-ones with valid=1.
  - Sets sticky output port timeout_err (1 bit, reset 0, cleared on accepted start). The sweep continues.
- Undefined: no watchdog and no timeout_err port; RUN waits indefinitely.

Decomposition:
- Package nq_pkg holds N_W, SUM_W, the state encoding constants (IDLE..DONE) and SUM_ALL_ONES.
- One natural sub-module, nq_result_ram: 2^N_W x SUM_W synchronous-read RAM plus a valid-bit vector with a bulk-clear input. The FSM lives in the top.

Test Plan:
- Bench uses a behavioural accelerator model that raises done K cycles after reset falls, returning known counts n=1..8 -> 1,0,0,2,10,4,40,92.
- Basic sweep: N_MIN=1, N_MAX=8, start pulse -> table reads n=1..8 return 1,0,0,2,10,4,40,92 with rd_valid=1. sweep_done=1, busy=0. rd_addr=9 -> rd_data=0, rd_valid=0.
- Reset timing: for each job, acc_reset is high exactly 4 cycles with acc_n stable, and acc_n advances by exactly 1 per job.
- Stale done: model holds done=1 from the previous job into the first RUN cycle -> that cycle is not captured; the correct new count is stored.
- start during busy: pulse start while n=5 is running -> no restart; sweep completes normally. Start again after DONE -> valid bits cleared, sweep repeats.
- Reset mid-sweep: assert reset while acc_n=6 in RUN -> next cycle busy=0, acc_reset=1, acc_n=1, all rd_valid=0.
- NQ_SWEEP_TIMEOUT_EN with TIMEOUT_CYCLES=100: model never raises done for n=3 -> table[3]=0xFFFFFF, timeout_err=1, and n=4 still completes with value 2.
